// File: rtl/apu_dispatcher_if.sv
// apu_dispatcher_if -- bundles every handshake/bus signal of the APU dispatcher.
//   core side     : instr_valid_i/instr_ready_o, instr_i, rs1_i, rs2_i, flags_i
//   accelerator   : apu_req/apu_gnt, apu_operands[2:0], apu_op, apu_flags_o,
//                   apu_rvalid, apu_result
//   writeback     : result_valid_o/result_ready_i, result_o, result_rd_o
//   status        : busy_o, protocol_err_o, done_count_o
// modport slave is the dispatcher; modport master is its environment.
interface apu_dispatcher_if;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [14:0] flags_i;

    logic        apu_req;
    logic        apu_gnt;
    logic [31:0] apu_operands [2:0];
    logic [5:0]  apu_op;
    logic [14:0] apu_flags_o;
    logic        apu_rvalid;
    logic [31:0] apu_result;

    logic        result_valid_o;
    logic [31:0] result_o;
    logic [4:0]  result_rd_o;
    logic        result_ready_i;

    logic        busy_o;
    logic        protocol_err_o;
    logic [15:0] done_count_o;

    modport slave (
        input  instr_valid_i, instr_i, rs1_i, rs2_i, flags_i,
        input  apu_gnt, apu_rvalid, apu_result, result_ready_i,
        output instr_ready_o, apu_req, apu_operands, apu_op, apu_flags_o,
        output result_valid_o, result_o, result_rd_o,
        output busy_o, protocol_err_o, done_count_o
    );

    modport master (
        output instr_valid_i, instr_i, rs1_i, rs2_i, flags_i,
        output apu_gnt, apu_rvalid, apu_result, result_ready_i,
        input  instr_ready_o, apu_req, apu_operands, apu_op, apu_flags_o,
        input  result_valid_o, result_o, result_rd_o,
        input  busy_o, protocol_err_o, done_count_o
    );
endinterface

// File: rtl/apu_dispatcher.sv
// apu_dispatcher -- queues vector instructions from the core and issues them one
// at a time to an accelerator (req/gnt, then a single rvalid completion pulse).
// Instructions that produce a scalar (vsetvli-class, vmv.x.s-class with rd!=0)
// hold their result in a writeback stage until the core takes it.
// Ports:
//   clk     : clock, rising edge
//   n_reset : asynchronous active-low reset
//   bus     : apu_dispatcher_if.slave (core, accelerator, writeback, status)
// Parameter FIFO_DEPTH: instruction queue depth (power of two, >= 2).
module apu_dispatcher #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    apu_dispatcher_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [14:0] flags;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_WB} state_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop;
    entry_t          head;

    state_t          state_q, state_d;
    logic            wb_req_q;
    logic [4:0]      rd_q;
    logic [31:0]     result_q;
    logic [15:0]     done_q;
    logic            err_q;
    logic            head_wb;

    // ---------------- instruction queue ----------------
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.instr_valid_i && !full;
    assign pop   = (state_q == S_REQ) && bus.apu_gnt;
    assign head  = mem[rd_ptr];

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{instr: bus.instr_i, rs1: bus.rs1_i,
                             rs2: bus.rs2_i, flags: bus.flags_i};
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scalar writeback needed: OP-V major opcode, either OPCFG (funct3=111,
    // vset*) or OPMVV funct6=010000 (VWXUNARY0, e.g. vmv.x.s), and rd != x0.
    assign head_wb = (head.instr[6:0] == 7'h57) &&
                     ((head.instr[14:12] == 3'b111) ||
                      ((head.instr[31:26] == 6'b010000) && (head.instr[14:12] == 3'b010))) &&
                     (head.instr[11:7] != 5'd0);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!empty)            state_d = S_REQ;
            S_REQ:  if (bus.apu_gnt)       state_d = S_RSP;
            S_RSP:  if (bus.apu_rvalid)    state_d = wb_req_q ? S_WB : S_IDLE;
            S_WB:   if (bus.result_ready_i) state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // ---------------- transaction registers ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wb_req_q <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (pop) begin
                wb_req_q <= head_wb;
                rd_q     <= head.instr[11:7];
            end
            if (state_q == S_RSP && bus.apu_rvalid) begin
                done_q <= done_q + 16'd1;
                if (wb_req_q) result_q <= bus.apu_result;
            end
            // A completion with nothing outstanding is dropped and flagged.
            if (bus.apu_rvalid && state_q != S_RSP)
                err_q <= 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign bus.instr_ready_o   = !full;
    assign bus.apu_req         = (state_q == S_REQ);
    assign bus.apu_operands[0] = head.instr;
    assign bus.apu_operands[1] = head.rs1;
    assign bus.apu_operands[2] = head.rs2;
    assign bus.apu_op          = head.instr[31:26];
    assign bus.apu_flags_o     = head.flags;
    assign bus.result_valid_o  = (state_q == S_WB);
    assign bus.result_o        = result_q;
    assign bus.result_rd_o     = rd_q;
    assign bus.busy_o          = !empty || (state_q != S_IDLE);
    assign bus.protocol_err_o  = err_q;
    assign bus.done_count_o    = done_q;
endmodule
